cpu_sequencer: RTL
==================

# cpu_sequencer

Instruction sequencer for the 4-bit CPU. It owns the program counter, the instruction register and the carry flag. It runs a two-phase FETCH/EXEC state machine paced by the prescaler tick. It decodes the latched opcode into the ALU source select and the register A/B load strobes, and supports conditional/unconditional jumps, halt and single-step. It sits between the instruction ROM and the ALU/register datapath and replaces the free-running PC incrementer.

## Interface
Parameters:
- none; opcode and select encodings come from `defines.v`.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- step_en  in  1  one-clk-wide pacing tick from the clock prescaler
- run  in  1  1 = free run; 0 = single-step mode
- step_req  in  1  debounced step button level, active-high; rising edge = one instruction
- inst  in  8  ROM data at address `pc`; [7:4] opcode, [3:0] immediate
- alu_carry  in  1  ALU carry out for the current EXEC operation
- pc  out  4  program counter / ROM address
- imm  out  4  ir[3:0], feeds ALU data_1
- alu_data_sel  out  2  ALU data_0 source: SEL_A / SEL_B / SEL_ZERO
- reg_a_load  out  1  register A write enable
- reg_b_load  out  1  register B write enable
- carry_flag  out  1  registered carry
- halted  out  1  1 in HALT state

## Operation
- Gated tick: `adv = step_en & (run | step_pending)`. The FSM only moves on `adv`.
- States: FETCH → EXEC → FETCH. Any state → HALT on HLT. HALT is left only by reset.
- FETCH + adv: `ir <= inst`, go to EXEC.
- EXEC: decode from ir. Strobes and the pc/carry update happen only on the EXEC+adv cycle.
- Opcodes (defines.v):
  - ADD_A 0000: A←A+imm, sel A
  - MOV_A_B 0001: A←B+imm, sel B
  - MOV_A_IMM 0011: A←imm, sel ZERO
  - ADD_B 0101: B←B+imm, sel B
  - MOV_B_A 0100: B←A+imm, sel A
  - MOV_B_IMM 0111: B←imm, sel ZERO
  - JMP 1111: pc←imm
  - JNC 1110: pc←imm if carry_flag=0, else pc+1
  - HLT 1011
  - all others: NOP
- ALU ops (six above): the target load is asserted, `carry_flag <= alu_carry`, `pc <= pc+1`.
- JMP/JNC: carry_flag cleared. NOP: pc+1, carry unchanged. HLT: pc unchanged, carry unchanged, go to HALT.
- pc arithmetic is mod 16: 15+1 → 0.
- alu_data_sel is SEL_ZERO outside EXEC and for non-ALU opcodes.
- Single-step: rising edge of step_req sets step_pending. It is cleared on EXEC+adv, so one request = one full instruction. A set on the same cycle as a clear wins (pending stays 1). While run=1, requests are ignored and pending is cleared.
- Changing run mid-instruction takes effect at the next step_en.

## Timing
- Reset (async assert, sync-safe release):
  - pc=0, ir=0, state=FETCH, carry_flag=0, halted=0, step_pending=0
  - reg_a_load=reg_b_load=0, alu_data_sel=SEL_ZERO
  - step_req edge detector history = 1, so a held button does not step after reset.
- One instruction = 2 adv ticks.
- reg_*_load are combinational (EXEC & adv & decode): high exactly one clk. The datapath registers capture on that edge, together with pc and carry_flag.
- alu_data_sel and imm are stable for the whole of EXEC, so the ALU settles before the strobe.
- inst must be valid one clk after a pc change (combinational or 1-cycle ROM).
- halted rises on the clk edge after HLT's EXEC+adv; all strobes are 0 thereafter.
- Reset asserted mid-EXEC: strobes drop immediately (async). No partial write occurs.

## Structure
- `defines.v`: opcode constants, SEL_A=2'd0 / SEL_B=2'd1 / SEL_ZERO=2'd2, state encodings.
- Sub-module `op_decoder` (combinational: opcode → sel, load_a, load_b, is_jmp, is_jnc, is_hlt, writes_carry). The FSM, pc, ir, carry and step logic stay in cpu_sequencer.

## Test plan
- Reset, run=1, ROM {0x33, 0x02, 0xF0}, step_en every 4 clk → A=3 then A=5. Load strobes are each 1 clk wide, 2 ticks apart; pc goes 0,1,2, then 0 after JMP.
- ADD_A with A=0xF, imm=1 → carry_flag=1. Next JNC 0x7 → pc=3 (not taken). Following JNC → carry=0, jump taken to 7.
- pc=15 with NOP → pc wraps to 0, carry unchanged.
- HLT at pc=4 → halted=1 after EXEC, pc stays 4, no strobes for 20 further ticks. reset_n low → pc=0, halted=0.
- run=0, two step_req pulses → exactly two instructions execute; state idles in FETCH between. Pulse coincident with EXEC completion → one extra instruction.
- reset_n asserted during EXEC with adv=1 → no load strobe, outputs at reset values the same cycle.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the 4-bit CPU sequencer: opcodes, ALU source selects and FSM states.
package cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A     = 4'b0000,
    OP_MOV_A_B   = 4'b0001,
    OP_MOV_A_IMM = 4'b0011,
    OP_MOV_B_A   = 4'b0100,
    OP_ADD_B     = 4'b0101,
    OP_MOV_B_IMM = 4'b0111,
    OP_HLT       = 4'b1011,
    OP_JNC       = 4'b1110,
    OP_JMP       = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_ZERO = 2'd2
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_op_decoder.sv
// Combinational opcode decode: ALU source select, register load enables and control-flow class.
module op_decoder
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] sel,
  output logic       load_a,
  output logic       load_b,
  output logic       is_jmp,
  output logic       is_jnc,
  output logic       is_hlt,
  output logic       writes_carry
);

  always_comb begin
    sel          = SEL_ZERO;
    load_a       = 1'b0;
    load_b       = 1'b0;
    is_jmp       = 1'b0;
    is_jnc       = 1'b0;
    is_hlt       = 1'b0;
    writes_carry = 1'b0;
    case (opcode)
      OP_ADD_A:     begin sel = SEL_A;    load_a = 1'b1; writes_carry = 1'b1; end
      OP_MOV_A_B:   begin sel = SEL_B;    load_a = 1'b1; writes_carry = 1'b1; end
      OP_MOV_A_IMM: begin sel = SEL_ZERO; load_a = 1'b1; writes_carry = 1'b1; end
      OP_ADD_B:     begin sel = SEL_B;    load_b = 1'b1; writes_carry = 1'b1; end
      OP_MOV_B_A:   begin sel = SEL_A;    load_b = 1'b1; writes_carry = 1'b1; end
      OP_MOV_B_IMM: begin sel = SEL_ZERO; load_b = 1'b1; writes_carry = 1'b1; end
      OP_JMP:       is_jmp = 1'b1;
      OP_JNC:       is_jnc = 1'b1;
      OP_HLT:       is_hlt = 1'b1;
      default:      ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Two-phase FETCH/EXEC instruction sequencer owning pc, ir and the carry flag,
// paced by the prescaler tick with free-run and single-step modes.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_en,
  input  logic       run,
  input  logic       step_req,
  input  logic [7:0] inst,
  input  logic       alu_carry,
  output logic [3:0] pc,
  output logic [3:0] imm,
  output logic [1:0] alu_data_sel,
  output logic       reg_a_load,
  output logic       reg_b_load,
  output logic       carry_flag,
  output logic       halted
);

  seq_state_e state;
  logic [7:0] ir;
  logic       step_pending;
  logic       step_prev;
  logic       adv;
  logic       exec_adv;
  logic       step_rise;

  logic [1:0] dec_sel;
  logic       dec_load_a;
  logic       dec_load_b;
  logic       dec_is_jmp;
  logic       dec_is_jnc;
  logic       dec_is_hlt;
  logic       dec_writes_carry;

  op_decoder u_op_decoder (
    .opcode       (ir[7:4]),
    .sel          (dec_sel),
    .load_a       (dec_load_a),
    .load_b       (dec_load_b),
    .is_jmp       (dec_is_jmp),
    .is_jnc       (dec_is_jnc),
    .is_hlt       (dec_is_hlt),
    .writes_carry (dec_writes_carry)
  );

  assign adv       = step_en & (run | step_pending);
  assign exec_adv  = (state == ST_EXEC) & adv;
  assign step_rise = step_req & ~step_prev;

  assign imm          = ir[3:0];
  assign alu_data_sel = (state == ST_EXEC) ? dec_sel : SEL_ZERO;
  // Strobes track the async-reset state directly, so a reset mid-EXEC kills them at once.
  assign reg_a_load   = exec_adv & dec_load_a;
  assign reg_b_load   = exec_adv & dec_load_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      carry_flag <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (adv) begin
            ir    <= inst;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (adv) begin
            state <= ST_FETCH;
            if (dec_is_hlt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (dec_is_jmp) begin
              pc         <= ir[3:0];
              carry_flag <= 1'b0;
            end else if (dec_is_jnc) begin
              pc         <= carry_flag ? pc + 4'd1 : ir[3:0];
              carry_flag <= 1'b0;
            end else begin
              pc <= pc + 4'd1;
              if (dec_writes_carry) carry_flag <= alu_carry;
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // History resets to 1 so a button held through reset is not seen as a new press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_prev    <= 1'b1;
      step_pending <= 1'b0;
    end else begin
      step_prev <= step_req;
      if (run)            step_pending <= 1'b0;
      else if (step_rise) step_pending <= 1'b1;
      else if (exec_adv)  step_pending <= 1'b0;
    end
  end

endmodule
